// File: rtl/adc_bitslip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_bitslip_ctrl
// Brief    : Word-alignment sequencer for one ISERDES2 ADC frame lane. It
//            issues BITSLIP strobes until the frame word is stable, then
//            tracks the lane and starts realignment on loss of lock.
// Revision : 1.0 - initial release
// ============================================================================
module adc_bitslip_ctrl #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b111000,
    parameter int               SETTLE  = 4,
    parameter int               NMATCH  = 16,
    parameter int               MAXSLIP = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             bs,
    output logic             aligned,
    output logic             err,
    output logic             lost,
    output logic [3:0]       slipcnt
);

    localparam int c_sw = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_mw = (NMATCH > 1) ? $clog2(NMATCH) : 1;

    localparam logic [c_sw-1:0] c_settle_last = c_sw'(SETTLE - 1);
    localparam logic [c_mw-1:0] c_match_last  = c_mw'(NMATCH - 1);
    localparam logic [3:0]      c_maxslip     = 4'(MAXSLIP);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_settle = 3'd1;
    localparam logic [2:0] c_st_check  = 3'd2;
    localparam logic [2:0] c_st_slip   = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;
    localparam logic [2:0] c_st_fail   = 3'd5;

    logic [2:0]      r_state;
    logic [c_sw-1:0] r_settle_cnt;
    logic [c_mw-1:0] r_match_cnt;
    logic            r_bs;
    logic            r_aligned;
    logic            r_err;
    logic            r_lost;
    logic [3:0]      r_slipcnt;

    logic [2:0]      w_state_nxt;
    logic [c_sw-1:0] w_settle_nxt;
    logic [c_mw-1:0] w_match_nxt;
    logic            w_bs_nxt;
    logic            w_aligned_nxt;
    logic            w_err_nxt;
    logic            w_lost_nxt;
    logic [3:0]      w_slipcnt_nxt;
    logic            w_match;

    assign w_match = (din == PATTERN);

    always_comb begin
        w_state_nxt   = r_state;
        w_settle_nxt  = r_settle_cnt;
        w_match_nxt   = r_match_cnt;
        w_bs_nxt      = 1'b0;
        w_aligned_nxt = r_aligned;
        w_err_nxt     = r_err;
        w_lost_nxt    = r_lost;
        w_slipcnt_nxt = r_slipcnt;

        case (r_state)
            c_st_idle, c_st_fail: begin
                w_aligned_nxt = 1'b0;
                if (start) begin
                    w_state_nxt   = c_st_settle;
                    w_settle_nxt  = '0;
                    w_match_nxt   = '0;
                    w_err_nxt     = 1'b0;
                    w_lost_nxt    = 1'b0;
                    w_slipcnt_nxt = '0;
                end
            end

            c_st_settle: begin
                if (r_settle_cnt == c_settle_last) begin
                    w_state_nxt  = c_st_check;
                    w_settle_nxt = '0;
                    w_match_nxt  = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + 1'b1;
                end
            end

            c_st_check: begin
                if (w_match) begin
                    if (r_match_cnt == c_match_last) begin
                        w_state_nxt   = c_st_done;
                        w_aligned_nxt = 1'b1;
                    end else begin
                        w_match_nxt = r_match_cnt + 1'b1;
                    end
                end else if (r_slipcnt < c_maxslip) begin
                    // Strobe and count land on the same edge, so SLIPCNT
                    // already includes the slip being issued.
                    w_state_nxt   = c_st_slip;
                    w_bs_nxt      = 1'b1;
                    w_slipcnt_nxt = r_slipcnt + 1'b1;
                end else begin
                    w_state_nxt = c_st_fail;
                    w_err_nxt   = 1'b1;
                end
            end

            c_st_slip: begin
                w_state_nxt  = c_st_settle;
                w_settle_nxt = '0;
            end

            c_st_done: begin
                // A restart request outranks a coincident mismatch.
                if (start) begin
                    w_state_nxt   = c_st_settle;
                    w_settle_nxt  = '0;
                    w_match_nxt   = '0;
                    w_aligned_nxt = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_lost_nxt    = 1'b0;
                    w_slipcnt_nxt = '0;
                end else if (!w_match) begin
                    w_state_nxt   = c_st_settle;
                    w_settle_nxt  = '0;
                    w_match_nxt   = '0;
                    w_aligned_nxt = 1'b0;
                    w_lost_nxt    = 1'b1;
                    w_slipcnt_nxt = '0;
                end else begin
                    w_aligned_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = c_st_idle;
                w_aligned_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_bs         <= 1'b0;
            r_aligned    <= 1'b0;
            r_err        <= 1'b0;
            r_lost       <= 1'b0;
            r_slipcnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_match_cnt  <= w_match_nxt;
            r_bs         <= w_bs_nxt;
            r_aligned    <= w_aligned_nxt;
            r_err        <= w_err_nxt;
            r_lost       <= w_lost_nxt;
            r_slipcnt    <= w_slipcnt_nxt;
        end
    end

    assign bs      = r_bs;
    assign aligned = r_aligned;
    assign err     = r_err;
    assign lost    = r_lost;
    assign slipcnt = r_slipcnt;

endmodule
`default_nettype wire
